// File: rtl/vcm_step_i2c_writer.sv
// Writes the 10-bit VCM focus position to the D8M VCM driver as a 3-byte I2C frame whenever STEP changes.
// Optional VCM_RATE_LIMIT_EN enforces MIN_GAP clocks between frame launches.
module vcm_step_i2c_writer #(
  parameter int unsigned CLK_DIV  = 125,
  parameter logic [6:0]  DEV_ADDR = 7'h0C,
  parameter logic [3:0]  SLEW_S   = 4'h0,
  parameter int unsigned MIN_GAP  = 4096
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic [9:0]  STEP,
  output logic        I2C_SCL,
  inout  wire         I2C_SDA,
  output logic        BUSY,
  output logic        ACK_ERR,
  output logic [9:0]  LAST_POS,
  output logic [15:0] WR_CNT
);

  localparam int unsigned TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);

  if (CLK_DIV < 2 || CLK_DIV > 1023 || MIN_GAP == 0) begin : g_param_check
    $error("vcm_step_i2c_writer: CLK_DIV must be 2..1023 and MIN_GAP nonzero");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_FREE} state_t;

  state_t        r_state, w_state_n;
  logic [1:0]    r_q, w_q_n;
  logic [2:0]    r_bit, w_bit_n;
  logic [1:0]    r_byte, w_byte_n;
  logic [TW-1:0] r_tick;
  logic [9:0]    r_d;
  logic          r_nack, r_valid, r_err, r_busy, r_scl, r_sda_low;
  logic [9:0]    r_last;
  logic [15:0]   r_cnt;
  logic [1:0]    r_sda_s;
  logic          w_qend, w_want, w_gap_ok, w_launch, w_commit, w_nack_set;
  logic          w_scl_n, w_sda_low_n;
  logic [7:0]    w_byte_val;

`ifdef VCM_RATE_LIMIT_EN
  localparam int unsigned HW = $clog2(MIN_GAP + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MIN_GAP - 1);
  logic [HW-1:0] r_hold;

  // Resets saturated so the first launch after reset is not held off.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n)                r_hold <= HOLD_LAST;
    else if (w_launch)           r_hold <= '0;
    else if (r_hold != HOLD_LAST) r_hold <= r_hold + 1'b1;
  end
  assign w_gap_ok = (r_hold == HOLD_LAST);
`else
  assign w_gap_ok = 1'b1;
`endif

  assign w_qend = (r_tick == TICK_LAST);
  assign w_want = (!r_valid || (STEP != r_last)) && w_gap_ok;

  always_comb begin
    w_state_n  = r_state;
    w_q_n      = r_q;
    w_bit_n    = r_bit;
    w_byte_n   = r_byte;
    w_launch   = 1'b0;
    w_commit   = 1'b0;
    w_nack_set = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_want) begin
        w_launch  = 1'b1;
        w_state_n = S_START;
        w_q_n     = '0;
      end
      S_START: if (w_qend) begin
        if (r_q == 2'd1) begin
          w_state_n = S_BIT;
          w_q_n     = '0;
          w_bit_n   = 3'd7;
          w_byte_n  = '0;
        end else begin
          w_q_n = r_q + 2'd1;
        end
      end
      S_BIT: if (w_qend) begin
        w_q_n = r_q + 2'd1;
        if (r_q == 2'd3) begin
          if (r_bit == 3'd0) w_state_n = S_ACK;
          else               w_bit_n   = r_bit - 3'd1;
        end
      end
      // NACK is captured mid-slot but the slot is completed so SDA never moves while SCL is high.
      S_ACK: if (w_qend) begin
        w_q_n = r_q + 2'd1;
        if (r_q == 2'd2 && r_sda_s[1]) w_nack_set = 1'b1;
        if (r_q == 2'd3) begin
          if (r_nack || r_byte == 2'd2) begin
            w_state_n = S_STOP;
          end else begin
            w_state_n = S_BIT;
            w_bit_n   = 3'd7;
            w_byte_n  = r_byte + 2'd1;
          end
        end
      end
      S_STOP: if (w_qend) begin
        if (r_q == 2'd2) begin
          w_state_n = S_FREE;
          w_q_n     = '0;
          w_commit  = !r_nack;
        end else begin
          w_q_n = r_q + 2'd1;
        end
      end
      S_FREE: if (w_qend) begin
        w_q_n = r_q + 2'd1;
        if (r_q == 2'd3) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase

    unique case (w_byte_n)
      2'd0:    w_byte_val = {DEV_ADDR, 1'b0};
      2'd1:    w_byte_val = {2'b00, r_d[9:4]};
      default: w_byte_val = {r_d[3:0], SLEW_S};
    endcase

    // Pin levels are derived from the upcoming state so they leave a flop glitch-free.
    w_scl_n     = 1'b1;
    w_sda_low_n = 1'b0;
    unique case (w_state_n)
      S_START: begin
        w_scl_n     = (w_q_n == 2'd0);
        w_sda_low_n = 1'b1;
      end
      S_BIT: begin
        w_scl_n     = (w_q_n == 2'd1) || (w_q_n == 2'd2);
        w_sda_low_n = !w_byte_val[w_bit_n];
      end
      S_ACK:  w_scl_n = (w_q_n == 2'd1) || (w_q_n == 2'd2);
      S_STOP: begin
        w_scl_n     = (w_q_n != 2'd0);
        w_sda_low_n = (w_q_n != 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state   <= S_IDLE;
      r_q       <= '0;
      r_bit     <= 3'd7;
      r_byte    <= '0;
      r_tick    <= '0;
      r_scl     <= 1'b1;
      r_sda_low <= 1'b0;
      r_busy    <= 1'b0;
      r_sda_s   <= 2'b11;
    end else begin
      r_state   <= w_state_n;
      r_q       <= w_q_n;
      r_bit     <= w_bit_n;
      r_byte    <= w_byte_n;
      r_tick    <= (r_state == S_IDLE || w_qend) ? '0 : r_tick + 1'b1;
      r_scl     <= w_scl_n;
      r_sda_low <= w_sda_low_n;
      r_busy    <= (w_state_n != S_IDLE);
      r_sda_s   <= {r_sda_s[0], I2C_SDA};
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_d     <= '0;
      r_nack  <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_last  <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_launch) begin
        r_d    <= STEP;
        r_nack <= 1'b0;
      end
      if (w_nack_set) begin
        r_nack <= 1'b1;
        r_err  <= 1'b1;
      end
      if (w_commit) begin
        r_last  <= r_d;
        r_valid <= 1'b1;
        r_cnt   <= r_cnt + 16'd1;
        r_err   <= 1'b0;
      end
    end
  end

  assign I2C_SCL  = r_scl;
  assign I2C_SDA  = r_sda_low ? 1'b0 : 1'bz;
  assign BUSY     = r_busy;
  assign ACK_ERR  = r_err;
  assign LAST_POS = r_last;
  assign WR_CNT   = r_cnt;

endmodule

// File: tb/tb_vcm_step_i2c_writer.sv
// Bench for vcm_step_i2c_writer: an I2C bus decoder plus ACK/NACK slave checks each frame against expected bytes.
module tb_vcm_step_i2c_writer;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned MIN_GAP = 1000;
  localparam logic [6:0]  DEV     = 7'h0C;
  localparam logic [3:0]  SLEW    = 4'h5;
  localparam int          FRAME   = 117 * CLK_DIV;
`ifdef VCM_RATE_LIMIT_EN
  localparam int          GAP     = (MIN_GAP > FRAME + 1) ? MIN_GAP : FRAME + 1;
`else
  localparam int          GAP     = FRAME + 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  step = '0;
  logic        scl, busy, ack_err;
  logic [9:0]  last_pos;
  logic [15:0] wr_cnt;
  wire         sda;
  logic        slave_low = 1'b0;

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  vcm_step_i2c_writer #(
    .CLK_DIV (CLK_DIV),
    .DEV_ADDR(DEV),
    .SLEW_S  (SLEW),
    .MIN_GAP (MIN_GAP)
  ) dut (
    .CLK     (clk),
    .RESET_n (rst_n),
    .STEP    (step),
    .I2C_SCL (scl),
    .I2C_SDA (sda),
    .BUSY    (busy),
    .ACK_ERR (ack_err),
    .LAST_POS(last_pos),
    .WR_CNT  (wr_cnt)
  );

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         n;
    logic [2:0] nak;
  } frame_t;

  frame_t frames[$];
  frame_t cur;
  int     launches[$];
  int     cyc = 0;
  int     bitcnt = 0;
  int     busy_rise = 0;
  int     busy_len = 0;
  logic   in_frame = 1'b0;
  logic   pscl = 1'b1, psda = 1'b1, pbusy = 1'b0;
  logic [7:0] sh = '0;
  logic   nack_arm = 1'b0;
  int     nack_byte = 0;

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0]  exp_last;
  logic [15:0] exp_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus decoder and slave: START/STOP/bits from SCL/SDA, ACK driven on the 8th SCL fall.
  initial begin
    cur = '{b0: 8'h00, b1: 8'h00, b2: 8'h00, n: 0, nak: 3'b000};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame  = 1'b0;
        bitcnt    = 0;
        slave_low = 1'b0;
      end else begin
        if (busy && !pbusy) begin
          busy_rise = cyc;
          launches.push_back(cyc);
        end
        if (!busy && pbusy) busy_len = cyc - busy_rise;
        if (pscl && scl && psda && !sda) begin
          in_frame = 1'b1;
          bitcnt   = 0;
          cur      = '{b0: 8'h00, b1: 8'h00, b2: 8'h00, n: 0, nak: 3'b000};
        end else if (pscl && scl && !psda && sda && in_frame) begin
          frames.push_back(cur);
          in_frame = 1'b0;
        end else if (!pscl && scl && in_frame) begin
          if (bitcnt < 8) begin
            sh = {sh[6:0], sda};
            bitcnt++;
          end else begin
            if (cur.n == 0) cur.b0 = sh;
            else if (cur.n == 1) cur.b1 = sh;
            else if (cur.n == 2) cur.b2 = sh;
            if (cur.n < 3) cur.nak[cur.n] = sda;
            cur.n++;
            bitcnt = 0;
          end
        end else if (pscl && !scl && in_frame) begin
          if (slave_low) slave_low = 1'b0;
          else if (bitcnt == 8) begin
            if (nack_arm && cur.n == nack_byte) nack_arm = 1'b0;
            else slave_low = 1'b1;
          end
        end
      end
      pbusy = busy;
      pscl  = scl;
      psda  = sda;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (frames.size() < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("frame_arrived", frames.size() >= n, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 3000) begin
      @(negedge clk);
      k++;
    end
    #1;
    check("busy_fell", busy, 0);
  endtask

  task automatic check_frame(input string tag, input frame_t f, input logic [9:0] p);
    int pv = int'(p);
    check({tag, "_nbytes"}, f.n, 3);
    check({tag, "_nak"}, f.nak, 0);
    check({tag, "_b0"}, f.b0, int'(DEV) * 2);
    check({tag, "_b1"}, f.b1, pv / 16);
    check({tag, "_b2"}, f.b2, (pv % 16) * 16 + int'(SLEW));
  endtask

  task automatic do_write(input string tag, input logic [9:0] p);
    frames.delete();
    step = p;
    wait_frames(1);
    wait_idle();
    if (frames.size() > 0) check_frame(tag, frames[0], p);
    exp_last = p;
    exp_cnt  = exp_cnt + 16'd1;
    check({tag, "_last_pos"}, last_pos, exp_last);
    check({tag, "_wr_cnt"}, wr_cnt, exp_cnt);
    check({tag, "_ack_err"}, ack_err, 0);
    check({tag, "_busy_len"}, busy_len, FRAME);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] p;
    int k;
    exp_last = '0;
    exp_cnt  = '0;

    repeat (3) @(negedge clk);
    check("rst_scl", scl, 1);
    check("rst_sda", sda, 1);
    check("rst_busy", busy, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_last_pos", last_pos, 0);
    check("rst_wr_cnt", wr_cnt, 0);

    rst_n = 1'b1;
    wait_frames(1);
    wait_idle();
    if (frames.size() > 0) check_frame("first", frames[0], 10'h000);
    exp_cnt = 16'd1;
    check("first_wr_cnt", wr_cnt, exp_cnt);
    check("first_last_pos", last_pos, exp_last);
    check("first_busy_len", busy_len, FRAME);
    repeat (600) @(negedge clk);
    check("first_no_extra", frames.size(), 1);

    do_write("enc", 10'h3F1);
    do_write("max", 10'h3FF);
    do_write("zero", 10'h000);
    for (int i = 0; i < 6; i++) begin
      p = 10'($urandom_range(0, 1023));
      if (p == exp_last) p = p ^ 10'h001;
      do_write("rand", p);
    end

    frames.delete();
    nack_byte = 1;
    nack_arm  = 1'b1;
    p = exp_last ^ 10'h2A5;
    step = p;
    wait_frames(1);
    wait_idle();
    if (frames.size() > 0) begin
      check("nack_nbytes", frames[0].n, 2);
      check("nack_nak", frames[0].nak[1:0], 2'b10);
      check("nack_b1", frames[0].b1, int'(p) / 16);
    end
    check("nack_ack_err", ack_err, 1);
    check("nack_wr_cnt", wr_cnt, exp_cnt);
    check("nack_last_pos", last_pos, exp_last);
    wait_frames(2);
    wait_idle();
    if (frames.size() > 1) check_frame("retry", frames[1], p);
    exp_last = p;
    exp_cnt  = exp_cnt + 16'd1;
    check("retry_ack_err", ack_err, 0);
    check("retry_wr_cnt", wr_cnt, exp_cnt);
    check("retry_last_pos", last_pos, exp_last);

    if (exp_last == 10'h010) do_write("pre_mid", 10'h020);
    frames.delete();
    step = 10'h010;
    k = 0;
    while (!(in_frame && cur.n == 1 && bitcnt == 3) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("mid_reached_byte1", k < 2000, 1);
    step = 10'h011;
    wait_frames(2);
    wait_idle();
    if (frames.size() > 1) begin
      check_frame("mid_first", frames[0], 10'h010);
      check_frame("mid_second", frames[1], 10'h011);
    end
    exp_cnt  = exp_cnt + 16'd2;
    exp_last = 10'h011;
    check("mid_wr_cnt", wr_cnt, exp_cnt);
    check("mid_last_pos", last_pos, exp_last);

    launches.delete();
    for (int i = 0; i < 3500; i++) begin
      @(negedge clk);
      step = step + 10'd1;
    end
    check("rate_launch_count", launches.size() >= 4, 1);
    for (int i = 1; i < 4; i++)
      if (i < launches.size()) check("rate_gap", launches[i] - launches[i-1], GAP);

    for (int i = 0; i < 3; i++) begin
      wait_idle();
      repeat (2) @(negedge clk);
    end
    step = step ^ 10'h200;
    k = 0;
    while (!(in_frame && cur.n == 2 && bitcnt == 2) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("rstmid_reached_byte2", k < 3000, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_scl", scl, 1);
    check("rstmid_sda", sda, 1);
    check("rstmid_busy", busy, 0);
    check("rstmid_last_pos", last_pos, 0);
    check("rstmid_wr_cnt", wr_cnt, 0);
    check("rstmid_ack_err", ack_err, 0);
    repeat (3) @(negedge clk);
    frames.delete();
    rst_n = 1'b1;
    wait_frames(1);
    wait_idle();
    if (frames.size() > 0) check_frame("post_rst", frames[0], step);
    check("post_rst_wr_cnt", wr_cnt, 1);
    check("post_rst_last_pos", last_pos, step);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vcm_step_i2c_writer.md
# vcm_step_i2c_writer

Consumes the 10-bit focus sweep position produced by the auto-focus step generator and writes it to the D8M voice-coil-motor (VCM) driver over I2C. Whenever the incoming `STEP` differs from the last value successfully written, the block launches one 3-byte I2C write frame: address, then two data bytes carrying D[9:0] and a slew code. It is the stage directly downstream of the step generator and drives the camera-module I2C pins.

## Interface
- `CLK_DIV`, 125: CLK cycles per SCL quarter-period. 125 gives 100 kHz SCL at 50 MHz. Legal range 2..1023.
- `DEV_ADDR`, 7'h0C: 7-bit VCM driver slave address; the R/W bit is always 0.
- `SLEW_S`, 4'h0: S[3:0] field placed in the low nibble of data byte 2.
- `MIN_GAP`, 4096: minimum CLK cycles from one frame start to the next frame start. Used only with `VCM_RATE_LIMIT_EN`.
- `CLK` input 1: system clock.
- `RESET_n` input 1: asynchronous, active-low reset.
- `STEP` input 10: requested VCM position, sampled only in IDLE.
- `I2C_SCL` output 1: I2C clock, driven push-pull (single master).
- `I2C_SDA` inout 1: open-drain. The block drives 0 or 1'bz and reads the pad.
- `BUSY` output 1: high from frame launch until the bus-free interval ends.
- `ACK_ERR` output 1: sticky flag, set on any NACK and cleared at the end of the next fully ACKed frame.
- `LAST_POS` output 10: last position that was fully ACKed.
- `WR_CNT` output 16: count of fully ACKed frames, wraps at 16'hFFFF→0.

## Operation
- **Reset values:** `I2C_SCL`=1, SDA released, `BUSY`=0, `ACK_ERR`=0, `LAST_POS`=0, `WR_CNT`=0, state=IDLE, internal `valid`=0.
- **Launch condition** (IDLE): launch when `valid`=0, or when `STEP`≠`LAST_POS`.
  - On launch, latch `STEP` into `D` and enter START. `BUSY`=1 from the next edge.
  - `STEP` changes during a frame are ignored; the value is re-evaluated on return to IDLE.
- **Frame bytes:**
  - Byte 0 = {DEV_ADDR, 1'b0}.
  - Byte 1 = {PD=0, FLAG=0, D[9:4]}.
  - Byte 2 = {D[3:0], SLEW_S}.
  - All bytes are sent MSB first, and each is followed by an ACK slot.
- **States:** IDLE → START → BIT → ACK → (BIT of next byte, or STOP) → FREE → IDLE.
  - A 2-bit quarter counter and a bit index 7..0 run within BIT.
- **ACK slot:** SDA is released and sampled at the end of quarter 2.
  - Pad=0 is an ACK.
  - Pad=1 is a NACK: go directly to STOP, set `ACK_ERR`, and leave `LAST_POS`, `valid` and `WR_CNT` unchanged, so the same position is retried after FREE.
- **After a fully ACKed frame** (3 ACKs), in STOP quarter 2:
  - `LAST_POS`←D, `valid`←1, `WR_CNT`+1, `ACK_ERR`←0.
- **Reset mid-frame:** all outputs return to reset values immediately, SDA is released, and SCL goes to 1. The slave may see an aborted frame; no bus recovery is performed.

## Timing
- One quarter = `CLK_DIV` CLK cycles, counted by a tick counter that reloads at each quarter boundary.
- **START (2 quarters):**
  - q0: SCL=1, SDA=0.
  - q1: SCL=0, SDA=0.
- **BIT and ACK (4 quarters each):**
  - q0: SCL=0, SDA←bit (or released for ACK).
  - q1: SCL=1.
  - q2: SCL=1.
  - q3: SCL=0.
  - SDA changes only in q0.
- **STOP (3 quarters):**
  - q0: SCL=0, SDA=0.
  - q1: SCL=1, SDA=0.
  - q2: SCL=1, SDA released.
- **FREE:** 4 quarters, then IDLE. `BUSY` falls on the first cycle of IDLE.
- **Frame length:** launch edge to `BUSY` fall = (2 + 27×4 + 3 + 4)×`CLK_DIV` = 117×`CLK_DIV` cycles.
- **Launch latency:** IDLE with a differing `STEP` → SCL/SDA START begins on the following cycle. Minimum IDLE dwell is 1 cycle.

## Configuration
- **`VCM_RATE_LIMIT_EN` defined:** a free-running holdoff counter restarts at each launch. IDLE does not launch until `MIN_GAP` cycles have elapsed since the previous launch. The effective period is max(`MIN_GAP`, 117×`CLK_DIV`+1), and the first launch after reset is not delayed.
- **`VCM_RATE_LIMIT_EN` undefined:** no holdoff counter exists, and launch is limited only by the frame length plus 1 IDLE cycle.

## Test plan
- **Reset then first write:**
  - Stimulus: `CLK_DIV`=4, `STEP`=10'h000 held, slave ACKs all.
  - Required response: exactly one frame with bytes 8'h18, 8'h00, 8'h00; `WR_CNT`=1; no further frames.
- **Encoding:**
  - Stimulus: `STEP`=10'h3F1, `SLEW_S`=4'h5.
  - Required response: bytes 8'h18, 8'h3F, 8'h15; `LAST_POS`=10'h3F1; `BUSY` high for exactly 468 cycles.
- **NACK retry:**
  - Stimulus: slave NACKs byte 1 once.
  - Required response: STOP follows that ACK slot; `ACK_ERR`=1; `WR_CNT` unchanged; the same frame repeats after FREE; `ACK_ERR`=0 after the successful retry.
- **Mid-frame change:**
  - Stimulus: `STEP` 10'h010→10'h011 during byte 1.
  - Required response: the current frame carries 10'h010; the next frame carries 10'h011; `WR_CNT`=+2.
- **Reset mid-frame:**
  - Stimulus: assert `RESET_n` during byte 2.
  - Required response: the same cycle gives SCL=1, SDA=Z, `BUSY`=0, `LAST_POS`=0; after release a new frame starts.
- **Rate limit:**
  - Stimulus: with `VCM_RATE_LIMIT_EN`, `MIN_GAP`=1000, `CLK_DIV`=4, and `STEP` incrementing every cycle.
  - Required response: consecutive launches exactly 1000 cycles apart.
  - Without the macro, consecutive launches are 469 cycles apart.
